// File: rtl/multicycle_controller.sv
// Control unit for the unified-memory multicycle ARM core: main FSM, ALU decoder,
// condition check and the registered NZCV flags.
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [19:0]        Instr,
  input  logic [3:0]         ALUFlags,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic [1:0]         RegSrc,
  output logic [1:0]         ImmSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUControl,
  output logic [1:0]         ResultSrc,
  output logic [STATE_W-1:0] State
);

  // state  | meaning
  // FETCH  | read instruction at PC, PC <= PC+4
  // DECODE | read registers, capture condition result
  // MEMADR | compute load/store address
  // MEMRD  | read data memory
  // MEMWB  | write loaded data to register file
  // MEMWR  | write store data to memory
  // EXECR  | ALU op with register operand
  // EXECI  | ALU op with immediate operand
  // ALUWB  | write ALU result to register file
  // BRANCH | PC <= PC+8+offset when condition holds
  typedef enum logic [3:0] {
    FETCH  = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD  = 4'd3, MEMWB = 4'd4,
    MEMWR  = 4'd5, EXECR  = 4'd6, EXECI  = 4'd7, ALUWB  = 4'd8, BRANCH = 4'd9
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       condex_q, condex_d;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] cmd;
  logic       unused_rn_rd;

  assign cond  = Instr[19:16];
  assign op    = Instr[15:14];
  assign funct = Instr[13:8];
  assign cmd   = funct[4:1];
  assign unused_rn_rd = ^Instr[7:0];

  logic [2:0] alu_dec;
  logic       no_write;
  logic [1:0] flag_w;
  logic       cond_ok;
  logic       n_f, z_f, c_f, v_f;
  logic       pc_write, mem_write, ir_write, reg_write;

  assign {n_f, z_f, c_f, v_f} = flags_q;

  always_comb begin
    alu_dec  = 3'b000;
    no_write = 1'b0;
    case (cmd)
      4'b0100: alu_dec = 3'b000;
      4'b0010: alu_dec = 3'b001;
      4'b0000: alu_dec = 3'b010;
      4'b1100: alu_dec = 3'b011;
      4'b0001: alu_dec = 3'b100;
      4'b1010: begin alu_dec = 3'b001; no_write = 1'b1; end
      default: alu_dec = 3'b000;
    endcase
    flag_w[1] = funct[0];
    flag_w[0] = funct[0] & ((alu_dec == 3'b000) | (alu_dec == 3'b001));
  end

  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      4'b0000: cond_ok = z_f;
      4'b0001: cond_ok = ~z_f;
      4'b0010: cond_ok = c_f;
      4'b0011: cond_ok = ~c_f;
      4'b0100: cond_ok = n_f;
      4'b0101: cond_ok = ~n_f;
      4'b0110: cond_ok = v_f;
      4'b0111: cond_ok = ~v_f;
      4'b1000: cond_ok = c_f & ~z_f;
      4'b1001: cond_ok = ~c_f | z_f;
      4'b1010: cond_ok = (n_f == v_f);
      4'b1011: cond_ok = (n_f != v_f);
      4'b1100: cond_ok = ~z_f & (n_f == v_f);
      4'b1101: cond_ok = z_f | (n_f != v_f);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = FETCH;
    flags_d    = flags_q;
    condex_d   = condex_q;
    pc_write   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b000;
    ResultSrc  = 2'b00;
    case (state_q)
      FETCH: begin
        state_d   = DECODE;
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        condex_d  = cond_ok;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (op)
          2'b01:   state_d = MEMADR;
          2'b00:   state_d = funct[5] ? EXECI : EXECR;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR: begin
        state_d = funct[0] ? MEMRD : MEMWR;
        ALUSrcB = 2'b01;
      end
      MEMRD: begin
        state_d = MEMWB;
        AdrSrc  = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_write = condex_q;
      end
      MEMWR: begin
        AdrSrc    = 1'b1;
        mem_write = condex_q;
      end
      EXECR, EXECI: begin
        state_d    = ALUWB;
        ALUSrcB    = (state_q == EXECI) ? 2'b01 : 2'b00;
        ALUControl = alu_dec;
        // Flags are registered here so the next instruction's condition sees them
        if (condex_q) begin
          if (flag_w[1]) flags_d[3:2] = ALUFlags[3:2];
          if (flag_w[0]) flags_d[1:0] = ALUFlags[1:0];
        end
      end
      ALUWB: reg_write = condex_q & ~no_write;
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        pc_write  = condex_q;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= FETCH;
      flags_q  <= 4'b0000;
      condex_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      flags_q  <= flags_d;
      condex_q <= condex_d;
    end
  end

  // Reset holds the FSM in FETCH, so the strobes must be masked directly by reset
  assign PCWrite  = pc_write & reset;
  assign IRWrite  = ir_write & reset;
  assign MemWrite = mem_write & reset;
  assign RegWrite = reg_write & reset;

  assign ImmSrc    = op;
  assign RegSrc[0] = (op == 2'b10);
  assign RegSrc[1] = (op == 2'b01) & ~funct[0];
  assign State     = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks ADD, LDR, STR, SUBS/BNE, CMP,
// mid-instruction reset and an undefined opcode, checking outputs on the falling edge.
module tb_multicycle_controller;

  logic        clk;
  logic        reset;
  logic [31:0] ir;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0]  RegSrc, ImmSrc, ALUSrcA, ALUSrcB, ResultSrc;
  logic [2:0]  ALUControl;
  logic [3:0]  State;

  int total = 0;
  int bad   = 0;

  assign Instr = ir[31:12];

  multicycle_controller #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .RegSrc(RegSrc), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ResultSrc(ResultSrc), .State(State)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt(input logic [3:0] exp_state);
    @(negedge clk);
    chk("state", {28'd0, State}, {28'd0, exp_state});
  endtask

  initial begin
    reset    = 1'b0;
    ir       = 32'hE2821005;
    ALUFlags = 4'b0000;
    repeat (2) @(negedge clk);
    chk("rst_state", {28'd0, State}, 32'd0);
    chk("rst_strobes", {28'd0, PCWrite, IRWrite, MemWrite, RegWrite}, 32'd0);
    chk("rst_flags", {28'd0, dut.flags_q}, 32'd0);

    // ADD R1,R2,#5
    reset = 1'b1;
    #1;
    chk("add_fetch_pc_ir", {30'd0, PCWrite, IRWrite}, 32'b11);
    chk("add_fetch_sel", {26'd0, ALUSrcA, ALUSrcB, ResultSrc}, 32'b01_10_10);
    nxt(4'd1);
    chk("add_dec_pc_ir", {30'd0, PCWrite, IRWrite}, 32'b00);
    ALUFlags = 4'b1111;
    nxt(4'd7);
    chk("add_execi_srcb", {30'd0, ALUSrcB}, 32'b01);
    chk("add_execi_aluctl", {29'd0, ALUControl}, 32'b000);
    chk("add_execi_regw", {31'd0, RegWrite}, 32'd0);
    nxt(4'd8);
    chk("add_aluwb_regw", {31'd0, RegWrite}, 32'd1);
    chk("add_no_flag_write", {28'd0, dut.flags_q}, 32'd0);

    // LDR
    nxt(4'd0);
    ir = 32'hE5910004;
    nxt(4'd1);
    nxt(4'd2);
    chk("ldr_memadr_srcb", {30'd0, ALUSrcB}, 32'b01);
    nxt(4'd3);
    chk("ldr_memrd_adrsrc", {31'd0, AdrSrc}, 32'd1);
    chk("ldr_memrd_memw", {31'd0, MemWrite}, 32'd0);
    nxt(4'd4);
    chk("ldr_memwb_res", {30'd0, ResultSrc}, 32'b01);
    chk("ldr_memwb_regw", {30'd0, RegWrite, MemWrite}, 32'b10);

    // STR
    nxt(4'd0);
    ir = 32'hE5810004;
    nxt(4'd1);
    chk("str_regsrc", {30'd0, RegSrc}, 32'b10);
    nxt(4'd2);
    nxt(4'd5);
    chk("str_memwr", {29'd0, MemWrite, AdrSrc, RegWrite}, 32'b110);
    nxt(4'd0);
    chk("str_memw_one_cycle", {31'd0, MemWrite}, 32'd0);

    // SUBS setting Z, then BNE not taken
    ir = 32'hE2533001;
    nxt(4'd1);
    nxt(4'd7);
    chk("subs_aluctl", {29'd0, ALUControl}, 32'b001);
    ALUFlags = 4'b0100;
    nxt(4'd8);
    chk("subs_flags_z", {28'd0, dut.flags_q}, 32'b0100);
    nxt(4'd0);
    ir = 32'h1AFFFFFD;
    nxt(4'd1);
    chk("bne_regsrc_imm", {28'd0, RegSrc, ImmSrc}, 32'b01_10);
    nxt(4'd9);
    chk("bne_untaken_pcw", {31'd0, PCWrite}, 32'd0);

    // SUBS setting C, then BNE taken
    nxt(4'd0);
    ir = 32'hE2533001;
    nxt(4'd1);
    nxt(4'd7);
    ALUFlags = 4'b0010;
    nxt(4'd8);
    chk("subs_flags_c", {28'd0, dut.flags_q}, 32'b0010);
    nxt(4'd0);
    ir = 32'h1AFFFFFD;
    nxt(4'd1);
    nxt(4'd9);
    chk("bne_taken_pcw", {31'd0, PCWrite}, 32'd1);
    chk("bne_sel", {28'd0, ALUSrcB, ResultSrc}, 32'b01_10);

    // CMP
    nxt(4'd0);
    ir = 32'hE1530004;
    nxt(4'd1);
    nxt(4'd6);
    chk("cmp_aluctl_srcb", {27'd0, ALUControl, ALUSrcB}, 32'b001_00);
    ALUFlags = 4'b1000;
    nxt(4'd8);
    chk("cmp_regw", {31'd0, RegWrite}, 32'd0);
    chk("cmp_flags", {28'd0, dut.flags_q}, 32'b1000);

    // Reset asserted during MEMWR
    nxt(4'd0);
    ir = 32'hE5810004;
    nxt(4'd1);
    nxt(4'd2);
    nxt(4'd5);
    chk("str2_memw", {31'd0, MemWrite}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_memw", {31'd0, MemWrite}, 32'd0);
    chk("midrst_state", {28'd0, State}, 32'd0);
    chk("midrst_flags", {28'd0, dut.flags_q}, 32'd0);
    chk("midrst_strobes", {28'd0, PCWrite, IRWrite, MemWrite, RegWrite}, 32'd0);

    // Undefined Op=11
    @(negedge clk);
    ir    = 32'hEC000000;
    reset = 1'b1;
    #1;
    chk("undef_fetch_state", {28'd0, State}, 32'd0);
    nxt(4'd1);
    chk("undef_dec_strobes", {28'd0, PCWrite, IRWrite, MemWrite, RegWrite}, 32'd0);
    nxt(4'd0);
    chk("undef_flags", {28'd0, dut.flags_q}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
